mem_port_arbiter: RTL and testbench

// - Shares one single-port unified memory between the fetch path (PC -> instruction) and the

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, tracking one read.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : gen_bad_lat
    $error("MEM_LAT must be 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gen_bad_starve
    $error("STARVE_MAX must be 1..15");
  end

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;
  typedef enum logic [0:0] {OwnFetch, OwnData} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [1:0] cnt_q, cnt_d;

  logic eligible, ret_cycle, if_gnt, d_gnt, rd_gnt, starve_force;

  // Outputs are forced low while reset is held, even combinational grants.
  assign eligible  = rst_ni && ((state_q == StIdle) || (cnt_q == 2'd0));
  assign ret_cycle = (state_q == StRdWait) && (cnt_q == 2'd0);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign starve_force = if_req_i && (starve_q >= 4'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = 4'd0;
    end else if (if_req_i && d_gnt) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign d_gnt  = eligible && d_req_i && !starve_force;
  assign if_gnt = eligible && if_req_i && !d_gnt;
  assign rd_gnt = if_gnt || (d_gnt && !d_we_i);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (rd_gnt) begin
      state_d = StRdWait;
      owner_d = d_gnt ? OwnData : OwnFetch;
      cnt_d   = 2'(MEM_LAT - 1);
    end else if (state_q == StRdWait) begin
      if (cnt_q == 2'd0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= OwnFetch;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    if_gnt_o    = if_gnt;
    d_gnt_o     = d_gnt;
    mem_en_o    = if_gnt || d_gnt;
    mem_we_o    = d_gnt && d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end
    if_rvalid_o = ret_cycle && (owner_q == OwnFetch);
    d_rvalid_o  = ret_cycle && (owner_q == OwnData);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    busy_o      = (state_q == StRdWait);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and random traffic
// checked against a timeline model (read issue time + fixed latency).
module tb_mem_port_arbiter;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (if_req && !if_gnt) |=> (if_req && $stable(if_addr)))
    else $error("protocol: fetch request dropped before grant");
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (d_req && !d_gnt) |=> (d_req && $stable(d_we) && $stable(d_addr) && $stable(d_wdata)))
    else $error("protocol: data request dropped before grant");

  typedef struct packed {
    logic ig, dg, irv, drv;
    logic [31:0] ird, drd;
    logic en, we;
    logic [31:0] ma, mwd;
    logic busy;
  } out_t;

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic [31:0] mr;
    out_t exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Timeline model state
  bit have_rd;
  int rd_t;
  bit rd_owner_d;
  int t = 0;
  int starve;
  logic a_ig, a_dg, a_irv, a_drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input out_t e);
    chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(e.ig));
    chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(e.dg));
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e.irv));
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(e.drv));
    chk({tag, ".if_rdata"}, if_rdata, e.ird);
    chk({tag, ".d_rdata"}, d_rdata, e.drd);
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(e.en));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(e.we));
    chk({tag, ".mem_addr"}, mem_addr, e.ma);
    chk({tag, ".mem_wdata"}, mem_wdata, e.mwd);
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  function automatic out_t mk(input logic ig, dg, irv, drv, input logic [31:0] rd,
                              input logic en, we, input logic [31:0] ma, mwd,
                              input logic bz);
    out_t o;
    o.ig = ig; o.dg = dg; o.irv = irv; o.drv = drv;
    o.ird = irv ? rd : 32'h0;
    o.drd = drv ? rd : 32'h0;
    o.en = en; o.we = we; o.ma = ma; o.mwd = mwd; o.busy = bz;
    return o;
  endfunction

  // Called just after a falling edge with inputs already set; returns after the next falling edge.
  task automatic step(input string tag);
    out_t e;
    bit ret, elig, force_if;
    e = '0;
    ret = 1'b0;
    #4;
    if (rst_n) begin
      ret  = have_rd && (t == rd_t + int'(MEM_LAT));
      elig = !have_rd || ret;
`ifdef ARB_STARVE_GUARD_EN
      force_if = if_req && (starve >= int'(STARVE_MAX));
`else
      force_if = 1'b0;
`endif
      e.dg = elig && d_req && !force_if;
      e.ig = elig && if_req && !e.dg;
      e.en = e.dg || e.ig;
      e.we = e.dg && d_we;
      e.ma = e.dg ? d_addr : (e.ig ? if_addr : 32'h0);
      e.mwd = e.dg ? d_wdata : 32'h0;
      e.irv = ret && !rd_owner_d;
      e.drv = ret && rd_owner_d;
      e.ird = e.irv ? mem_rdata : 32'h0;
      e.drd = e.drv ? mem_rdata : 32'h0;
      e.busy = have_rd;
    end
    chk_out(tag, e);
    a_ig = if_gnt; a_dg = d_gnt; a_irv = if_rvalid; a_drv = d_rvalid;
    @(posedge clk);
    if (rst_n) begin
      if (e.ig || (e.dg && !d_we)) begin
        have_rd = 1'b1; rd_t = t; rd_owner_d = e.dg;
      end else if (ret) begin
        have_rd = 1'b0;
      end
      if (e.ig) starve = 0;
      else if (if_req && e.dg) starve++;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
  endtask

  task automatic clear_model();
    have_rd = 0; rd_t = 0; rd_owner_d = 0; starve = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    if_req = 1'($urandom); if_addr = $urandom; d_req = 1'($urandom); d_we = 1'($urandom);
    d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
    step("reset");
    idle_inputs();
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];

  initial begin
    int first_ig, n_dg, guard;
    idle_inputs();
    rst_n = 1'b0;
    clear_model();

    // Row outputs: ig dg irv drv rdata en we mem_addr mem_wdata busy
    tbl[0]  = '{1, 32'h10, 0, 0, 0, 0, 32'h0, mk(1,0,0,0,0,1,0,32'h10,0,0)};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h0, mk(0,0,0,0,0,0,0,0,0,1)};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h00A00093, mk(0,0,1,0,32'h00A00093,0,0,0,0,1)};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 32'h0, mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[4]  = '{1, 32'h14, 1, 0, 32'h200, 0, 32'h0, mk(0,1,0,0,0,1,0,32'h200,0,0)};
    tbl[5]  = '{1, 32'h14, 0, 0, 0, 0, 32'h0, mk(0,0,0,0,0,0,0,0,0,1)};
    tbl[6]  = '{1, 32'h14, 0, 0, 0, 0, 32'h1234, mk(1,0,0,1,32'h1234,1,0,32'h14,0,1)};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 32'hFFFF, mk(0,0,0,0,0,0,0,0,0,1)};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 32'h5555, mk(0,0,1,0,32'h5555,0,0,0,0,1)};
    tbl[9]  = '{1, 32'h18, 1, 1, 32'h40, 32'hDEADBEEF, 32'h0,
                mk(0,1,0,0,0,1,1,32'h40,32'hDEADBEEF,0)};
    tbl[10] = '{1, 32'h18, 0, 0, 0, 0, 32'h0, mk(1,0,0,0,0,1,0,32'h18,0,0)};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 32'hFFFF, mk(0,0,0,0,0,0,0,0,0,1)};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 32'h77, mk(0,0,1,0,32'h77,0,0,0,0,1)};

    #2;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia;
      d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
      mem_rdata = tbl[i].mr;
      #4;
      chk_out($sformatf("tbl%0d", i), tbl[i].exp);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // Starvation: stores held back to back with a waiting fetch
    do_reset();
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = $urandom; d_wdata = $urandom;
    first_ig = -1; n_dg = 0;
    for (int c = 0; c < 8; c++) begin
      step("starve");
      if (a_ig && first_ig < 0) first_ig = c;
      if (a_dg && first_ig < 0) n_dg++;
      if (a_ig) if_req = 0;
      if (a_dg) begin d_addr = $urandom; d_wdata = $urandom; end
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve.first_if_gnt_cycle", 32'(first_ig), 32'd4);
    chk("starve.d_gnt_before_fetch", 32'(n_dg), 32'd4);
`else
    chk("starve.first_if_gnt_cycle", 32'(first_ig), 32'hFFFFFFFF);
    chk("starve.d_gnt_before_fetch", 32'(n_dg), 32'd8);
`endif
    guard = 0;
    while ((if_req || d_req) && guard < 20) begin
      step("drain");
      if (a_dg) d_req = 0;
      if (a_ig) if_req = 0;
      guard++;
    end
    chk("drain.timeout", 32'(if_req || d_req), 32'd0);

    // Reset in the middle of a read
    idle_inputs();
    for (int c = 0; c < 3; c++) step("pre_mid");
    if_req = 1; if_addr = 32'h44;
    step("mid_issue");
    chk("mid_issue.gnt", 32'(a_ig), 32'd1);
    idle_inputs();
    #2 rst_n = 1'b0;
    clear_model();
    #2;
    chk_out("mid_reset", '0);
    @(negedge clk);
    do_reset();
    for (int c = 0; c < int'(MEM_LAT) + 1; c++) begin
      mem_rdata = $urandom;
      step("post_reset");
      chk("post_reset.no_rvalid", 32'({a_irv, a_drv}), 32'd0);
    end
    if_req = 1; if_addr = 32'h100; mem_rdata = 0;
    step("fresh_issue");
    if_req = 0;
    for (int c = 1; c < int'(MEM_LAT); c++) step("fresh_wait");
    mem_rdata = 32'hCAFE0001;
    step("fresh_ret");
    chk("fresh.if_rvalid", 32'(a_irv), 32'd1);

    // Random traffic against the timeline model
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      mem_rdata = $urandom;
      step("rand");
      if (!if_req || a_ig) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (!d_req || a_dg) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_we = 1'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
